// File: rtl/rfm_cmd_gen_pkg.sv
// Shared definitions for the RFM command generator: FSM state encoding,
// default parameter values and the saturating helper used by the RAA counter.
package rfm_cmd_gen_pkg;

    localparam int DEF_RFM_TH      = 20;
    localparam int DEF_RAA_MAX     = 60;
    localparam int DEF_RAA_BITS    = 8;
    localparam int DEF_ADDR_SIZE   = 18;
    localparam int DEF_ACT_GAP     = 5;
    localparam int DEF_NRR_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACT_WAIT  = 2'd1,
        ST_RFM_WAIT  = 2'd2,
        ST_RFM_DRAIN = 2'd3
    } state_t;

    // Saturate a signed sum into the range 0 .. max_value.
    function automatic int clamp_raa(input int value, input int max_value);
        if (value < 0) begin
            return 0;
        end
        if (value > max_value) begin
            return max_value;
        end
        return value;
    endfunction

endpackage

// File: rtl/rfm_raa_counter.sv
// Rolling accumulated activation counter: one +1 event (ACT) and two
// -RFM_TH events (REF, completed RFM). Events of the same cycle are summed
// before the result is saturated to the counter range.
module rfm_raa_counter
    import rfm_cmd_gen_pkg::*;
#(
    parameter int RFM_TH   = DEF_RFM_TH,
    parameter int RAA_BITS = DEF_RAA_BITS
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                inc,
    input  logic                dec_a,
    input  logic                dec_b,
    output logic [RAA_BITS-1:0] raa
);

    localparam int RAA_TOP = (1 << RAA_BITS) - 1;

    int                  sum;
    logic [RAA_BITS-1:0] raa_next;

    // Sum all events of this cycle, then clamp into 0 .. 2^RAA_BITS-1
    always_comb begin
        sum      = int'(raa) + int'(inc) - RFM_TH * (int'(dec_a) + int'(dec_b));
        raa_next = RAA_BITS'(clamp_raa(sum, RAA_TOP));
    end

    // Counter register, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            raa <= '0;
        end else begin
            raa <= raa_next;
        end
    end

endmodule

// File: rtl/rfm_cmd_gen.sv
// Per-bank RFM initiator: forwards scheduler ACTs to the bank RFM unit,
// tracks RAA, issues RFM at threshold (forced at RAA_MAX) and turns the
// unit's NRR response into a completion or timeout report.
module rfm_cmd_gen
    import rfm_cmd_gen_pkg::*;
#(
    parameter int RFM_TH      = DEF_RFM_TH,
    parameter int RAA_MAX     = DEF_RAA_MAX,
    parameter int RAA_BITS    = DEF_RAA_BITS,
    parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
    parameter int ACT_GAP     = DEF_ACT_GAP,
    parameter int NRR_TIMEOUT = DEF_NRR_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req_valid,
    input  logic [ADDR_SIZE-1:0] req_addr,
    output logic                 req_ready,
    input  logic                 ref_cmd,
    output logic                 act_cmd,
    output logic [ADDR_SIZE-1:0] act_addr,
    output logic                 rfm_cmd,
    input  logic                 nrr_cmd,
    input  logic [ADDR_SIZE-1:0] nrr_addr,
    output logic                 nrr_done,
    output logic [ADDR_SIZE-1:0] nrr_done_addr,
    output logic                 rfm_timeout,
    output logic [RAA_BITS-1:0]  raa_cnt
);

    localparam int CNT_BITS = $clog2(ACT_GAP + NRR_TIMEOUT + 2);

    state_t              state;
    state_t              state_next;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] cnt_next;
    logic                nrr_q;
    logic                nrr_rise;
    logic [RAA_BITS-1:0] raa;
    logic                raa_full;
    logic                raa_th;
    logic                do_act;
    logic                do_rfm;
    logic                do_done;
    logic                do_timeout;

    assign nrr_rise  = nrr_cmd && !nrr_q;
    assign raa_full  = raa >= RAA_BITS'(RAA_MAX);
    assign raa_th    = raa >= RAA_BITS'(RFM_TH);
    assign req_ready = (state == ST_IDLE) && !raa_full;
    assign raa_cnt   = raa;

    rfm_raa_counter #(
        .RFM_TH   (RFM_TH),
        .RAA_BITS (RAA_BITS)
    ) u_raa (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (do_act),
        .dec_a (ref_cmd),
        .dec_b (do_done),
        .raa   (raa)
    );

    // State and shared gap/timeout/drain counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state; the counter restarts at 0 on every state change
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (raa_full) begin
                    state_next = ST_RFM_WAIT;
                end else if (req_valid) begin
                    state_next = ST_ACT_WAIT;
                end else if (raa_th) begin
                    state_next = ST_RFM_WAIT;
                end
            end
            ST_ACT_WAIT: begin
                if (cnt == CNT_BITS'(ACT_GAP - 1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            ST_RFM_WAIT: begin
                if (nrr_rise || (cnt == CNT_BITS'(NRR_TIMEOUT - 1))) begin
                    state_next = ST_RFM_DRAIN;
                    cnt_next   = '0;
                end
            end
            ST_RFM_DRAIN: begin
                if (nrr_cmd) begin
                    cnt_next = '0;
                end else if (cnt == CNT_BITS'(1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Per-cycle events; forced RFM beats ACT, ACT beats threshold RFM
    always_comb begin
        do_act     = 1'b0;
        do_rfm     = 1'b0;
        do_done    = 1'b0;
        do_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                do_act = !raa_full && req_valid;
                do_rfm = raa_full || (!req_valid && raa_th);
            end
            ST_RFM_WAIT: begin
                do_done    = nrr_rise;
                do_timeout = !nrr_rise && (cnt == CNT_BITS'(NRR_TIMEOUT - 1));
            end
            default: begin
                do_act = 1'b0;
            end
        endcase
    end

    // Registered pulses, held addresses and the NRR edge-detect flop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_cmd       <= 1'b0;
            act_addr      <= '0;
            rfm_cmd       <= 1'b0;
            nrr_done      <= 1'b0;
            nrr_done_addr <= '0;
            rfm_timeout   <= 1'b0;
            nrr_q         <= 1'b0;
        end else begin
            act_cmd     <= do_act;
            rfm_cmd     <= do_rfm;
            nrr_done    <= do_done;
            rfm_timeout <= do_timeout;
            nrr_q       <= nrr_cmd;
            if (do_act) begin
                act_addr <= req_addr;
            end
            if (do_done) begin
                nrr_done_addr <= nrr_addr;
            end
        end
    end

endmodule

// File: tb/tb_rfm_cmd_gen.sv
// Self-checking bench for rfm_cmd_gen: a short hand-computed vector table,
// directed multi-cycle sequences, and random traffic, all run in lockstep
// with a timestamp-based reference model.
module tb_rfm_cmd_gen;

    localparam int RFM_TH      = 20;
    localparam int RAA_MAX     = 60;
    localparam int RAA_BITS    = 8;
    localparam int ADDR_SIZE   = 18;
    localparam int ACT_GAP     = 5;
    localparam int NRR_TIMEOUT = 16;

    typedef logic [ADDR_SIZE-1:0] addr_t;

    typedef struct {
        logic          v;
        addr_t         a;
        logic          r;
        logic          n;
        addr_t         na;
        logic          ready;
        logic          act;
        logic          rfm;
        logic          done;
        logic [7:0]    raa;
        addr_t         act_addr;
    } vec_t;

    logic                clk = 1'b0;
    logic                rstn;
    logic                req_valid;
    addr_t               req_addr;
    logic                req_ready;
    logic                ref_cmd;
    logic                act_cmd;
    addr_t               act_addr;
    logic                rfm_cmd;
    logic                nrr_cmd;
    addr_t               nrr_addr;
    logic                nrr_done;
    addr_t               nrr_done_addr;
    logic                rfm_timeout;
    logic [RAA_BITS-1:0] raa_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: timestamps of when the block frees up, when the
    // pending RFM was issued, and the drain low-run length
    int    m_cyc;
    int    m_raa;
    int    m_ready_at;
    int    m_rfm_at;
    int    m_lows;
    bit    m_draining;
    bit    m_prev_nrr;
    bit    e_act;
    bit    e_rfm;
    bit    e_done;
    bit    e_to;
    addr_t e_act_addr;
    addr_t e_done_addr;

    always #5 clk = ~clk;

    rfm_cmd_gen #(
        .RFM_TH      (RFM_TH),
        .RAA_MAX     (RAA_MAX),
        .RAA_BITS    (RAA_BITS),
        .ADDR_SIZE   (ADDR_SIZE),
        .ACT_GAP     (ACT_GAP),
        .NRR_TIMEOUT (NRR_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .ref_cmd       (ref_cmd),
        .act_cmd       (act_cmd),
        .act_addr      (act_addr),
        .rfm_cmd       (rfm_cmd),
        .nrr_cmd       (nrr_cmd),
        .nrr_addr      (nrr_addr),
        .nrr_done      (nrr_done),
        .nrr_done_addr (nrr_done_addr),
        .rfm_timeout   (rfm_timeout),
        .raa_cnt       (raa_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc       = 0;
        m_raa       = 0;
        m_ready_at  = 0;
        m_rfm_at    = -1;
        m_lows      = 0;
        m_draining  = 1'b0;
        m_prev_nrr  = 1'b0;
        e_act       = 1'b0;
        e_rfm       = 1'b0;
        e_done      = 1'b0;
        e_to        = 1'b0;
        e_act_addr  = '0;
        e_done_addr = '0;
    endtask

    function automatic bit model_idle();
        return (m_rfm_at < 0) && !m_draining && (m_cyc >= m_ready_at);
    endfunction

    // Advance the model by one cycle given this cycle's inputs
    task automatic model_step(input logic v, input addr_t a, input logic r, input logic n, input addr_t na);
        int delta;
        bit idle;
        delta  = 0;
        idle   = model_idle();
        e_act  = 1'b0;
        e_rfm  = 1'b0;
        e_done = 1'b0;
        e_to   = 1'b0;
        if (idle) begin
            if (m_raa >= RAA_MAX) begin
                e_rfm    = 1'b1;
                m_rfm_at = m_cyc + 1;
            end else if (v) begin
                e_act      = 1'b1;
                e_act_addr = a;
                delta      = delta + 1;
                m_ready_at = m_cyc + 1 + ACT_GAP;
            end else if (m_raa >= RFM_TH) begin
                e_rfm    = 1'b1;
                m_rfm_at = m_cyc + 1;
            end
        end else if (m_rfm_at >= 0) begin
            if (n && !m_prev_nrr) begin
                e_done      = 1'b1;
                e_done_addr = na;
                delta       = delta - RFM_TH;
                m_rfm_at    = -1;
                m_draining  = 1'b1;
                m_lows      = 0;
            end else if (m_cyc - m_rfm_at == NRR_TIMEOUT - 1) begin
                e_to       = 1'b1;
                m_rfm_at   = -1;
                m_draining = 1'b1;
                m_lows     = 0;
            end
        end else if (m_draining) begin
            m_lows = n ? 0 : m_lows + 1;
            if (m_lows == 2) begin
                m_draining = 1'b0;
                m_ready_at = m_cyc + 1;
            end
        end
        if (r) begin
            delta = delta - RFM_TH;
        end
        m_raa = m_raa + delta;
        if (m_raa < 0) m_raa = 0;
        if (m_raa > 255) m_raa = 255;
        m_prev_nrr = n;
        m_cyc++;
    endtask

    task automatic compare_model();
        checkOutput("m_req_ready", 32'(req_ready), 32'(model_idle() && (m_raa < RAA_MAX)));
        checkOutput("m_raa_cnt", 32'(raa_cnt), 32'(m_raa));
        checkOutput("m_act_cmd", 32'(act_cmd), 32'(e_act));
        checkOutput("m_act_addr", 32'(act_addr), 32'(e_act_addr));
        checkOutput("m_rfm_cmd", 32'(rfm_cmd), 32'(e_rfm));
        checkOutput("m_nrr_done", 32'(nrr_done), 32'(e_done));
        checkOutput("m_nrr_done_addr", 32'(nrr_done_addr), 32'(e_done_addr));
        checkOutput("m_rfm_timeout", 32'(rfm_timeout), 32'(e_to));
    endtask

    // One clock cycle: check the current cycle, drive inputs, move to the next
    task automatic applyStimulus(input logic v, input addr_t a, input logic r, input logic n, input addr_t na);
        compare_model();
        req_valid = v;
        req_addr  = a;
        ref_cmd   = r;
        nrr_cmd   = n;
        nrr_addr  = na;
        model_step(v, a, r, n, na);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        ref_cmd   = 1'b0;
        nrr_cmd   = 1'b0;
        nrr_addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
    endtask

    // Hold req_valid until the target number of ACT pulses has been seen
    task automatic run_acts(input int target, output int acts, output bit saw_rfm);
        acts    = 0;
        saw_rfm = 1'b0;
        for (int i = 0; i < target * (ACT_GAP + 1) + 20 && acts < target; i++) begin
            applyStimulus(1'b1, addr_t'(i * 7 + 32'h101), 1'b0, 1'b0, '0);
            if (act_cmd) acts++;
            if (rfm_cmd) saw_rfm = 1'b1;
        end
    endtask

    task automatic wait_rfm(output int n);
        n = 0;
        for (int i = 0; i < 30 && !rfm_cmd; i++) begin
            idle_cycle();
            n++;
        end
    endtask

    initial begin
        vec_t  vecs[14];
        int    acts;
        int    n;
        bit    saw;
        bit    nlev;

        // Table from reset: inputs of cycle i; ready is for cycle i, the rest for cycle i+1
        vecs[0]  = '{1'b1, 18'h0000A, 1'b0, 1'b0, 18'h0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 18'h0000A};
        vecs[1]  = '{1'b1, 18'h00BBB, 1'b1, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 18'h0000A};
        vecs[2]  = '{1'b0, 18'h0,     1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 18'h0000A};
        vecs[3]  = '{1'b0, 18'h0,     1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 18'h0000A};
        vecs[4]  = '{1'b0, 18'h0,     1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 18'h0000A};
        vecs[5]  = '{1'b0, 18'h0,     1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 18'h0000A};
        vecs[6]  = '{1'b1, 18'h3FFFF, 1'b0, 1'b0, 18'h0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 18'h3FFFF};
        vecs[7]  = '{1'b0, 18'h0,     1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 18'h3FFFF};
        vecs[8]  = '{1'b1, 18'h00055, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 18'h3FFFF};
        vecs[9]  = '{1'b0, 18'h0,     1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 18'h3FFFF};
        vecs[10] = '{1'b0, 18'h0,     1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 18'h3FFFF};
        vecs[11] = '{1'b0, 18'h0,     1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 18'h3FFFF};
        vecs[12] = '{1'b1, 18'h12345, 1'b1, 1'b0, 18'h0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 18'h12345};
        vecs[13] = '{1'b0, 18'h0,     1'b0, 1'b1, 18'h1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 18'h12345};

        // Reset values
        do_reset();
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_raa_cnt", 32'(raa_cnt), 32'd0);
        checkOutput("rst_act_cmd", 32'(act_cmd), 32'd0);
        checkOutput("rst_rfm_cmd", 32'(rfm_cmd), 32'd0);

        // Vector table
        for (int i = 0; i < 14; i++) begin
            checkOutput($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(vecs[i].ready));
            applyStimulus(vecs[i].v, vecs[i].a, vecs[i].r, vecs[i].n, vecs[i].na);
            checkOutput($sformatf("tbl%0d_act", i), 32'(act_cmd), 32'(vecs[i].act));
            checkOutput($sformatf("tbl%0d_rfm", i), 32'(rfm_cmd), 32'(vecs[i].rfm));
            checkOutput($sformatf("tbl%0d_done", i), 32'(nrr_done), 32'(vecs[i].done));
            checkOutput($sformatf("tbl%0d_raa", i), 32'(raa_cnt), 32'(vecs[i].raa));
            checkOutput($sformatf("tbl%0d_act_addr", i), 32'(act_addr), 32'(vecs[i].act_addr));
        end

        // Continuous traffic postpones RFM past the threshold, then RFM + NRR
        do_reset();
        run_acts(19, acts, saw);
        checkOutput("post_acts19", 32'(acts), 32'd19);
        checkOutput("post_raa19", 32'(raa_cnt), 32'd19);
        checkOutput("post_no_rfm19", 32'(saw), 32'd0);
        run_acts(2, acts, saw);
        checkOutput("post_acts21", 32'(acts), 32'd2);
        checkOutput("post_raa21", 32'(raa_cnt), 32'd21);
        checkOutput("post_no_rfm21", 32'(saw), 32'd0);
        wait_rfm(n);
        checkOutput("post_rfm_delay", 32'(n), 32'(ACT_GAP + 1));
        repeat (6) idle_cycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 18'h155);
        checkOutput("post_nrr_done", 32'(nrr_done), 32'd1);
        checkOutput("post_nrr_addr", 32'(nrr_done_addr), 32'h155);
        checkOutput("post_nrr_raa", 32'(raa_cnt), 32'd1);
        repeat (4) idle_cycle();

        // req_valid held high until RAA_MAX forces an RFM
        do_reset();
        acts = 0;
        saw  = 1'b0;
        for (int i = 0; i < 450 && !rfm_cmd; i++) begin
            applyStimulus(1'b1, addr_t'(i + 3), 1'b0, 1'b0, '0);
            if (act_cmd) acts++;
            if (req_ready && raa_cnt >= RAA_BITS'(RAA_MAX)) saw = 1'b1;
        end
        checkOutput("max_rfm_seen", 32'(rfm_cmd), 32'd1);
        checkOutput("max_acts", 32'(acts), 32'd60);
        checkOutput("max_raa", 32'(raa_cnt), 32'd60);
        checkOutput("max_ready_blocked", 32'(saw), 32'd0);
        applyStimulus(1'b1, 18'h77, 1'b0, 1'b1, 18'h2AAAA);
        checkOutput("max_nrr_done", 32'(nrr_done), 32'd1);
        checkOutput("max_nrr_raa", 32'(raa_cnt), 32'd40);
        repeat (6) applyStimulus(1'b1, 18'h78, 1'b0, 1'b0, '0);

        // No NRR: timeout after NRR_TIMEOUT cycles, then a late NRR is ignored
        do_reset();
        run_acts(20, acts, saw);
        wait_rfm(n);
        checkOutput("to_rfm_seen", 32'(rfm_cmd), 32'd1);
        n = 0;
        for (int i = 0; i < 40 && !rfm_timeout; i++) begin
            idle_cycle();
            n++;
        end
        checkOutput("to_delay", 32'(n), 32'(NRR_TIMEOUT));
        checkOutput("to_raa", 32'(raa_cnt), 32'd20);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 18'h3C3C);
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (nrr_done) saw = 1'b1;
            idle_cycle();
        end
        checkOutput("to_late_nrr_ignored", 32'(saw), 32'd0);

        // REF coinciding with NRR at raa=30
        do_reset();
        run_acts(30, acts, saw);
        wait_rfm(n);
        checkOutput("refnrr_raa_before", 32'(raa_cnt), 32'd30);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 18'h0AB0);
        checkOutput("refnrr_done", 32'(nrr_done), 32'd1);
        checkOutput("refnrr_raa", 32'(raa_cnt), 32'd0);
        repeat (4) idle_cycle();

        // REF coinciding with an ACT at raa=5
        do_reset();
        run_acts(5, acts, saw);
        for (int i = 0; i < 10 && !req_ready; i++) idle_cycle();
        checkOutput("refact_raa_before", 32'(raa_cnt), 32'd5);
        applyStimulus(1'b1, 18'h1234, 1'b1, 1'b0, '0);
        checkOutput("refact_act", 32'(act_cmd), 32'd1);
        checkOutput("refact_raa", 32'(raa_cnt), 32'd0);

        // Asynchronous reset three cycles into an RFM
        do_reset();
        run_acts(20, acts, saw);
        wait_rfm(n);
        repeat (3) idle_cycle();
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("arst_act_cmd", 32'(act_cmd), 32'd0);
        checkOutput("arst_act_addr", 32'(act_addr), 32'd0);
        checkOutput("arst_rfm_cmd", 32'(rfm_cmd), 32'd0);
        checkOutput("arst_nrr_done", 32'(nrr_done), 32'd0);
        checkOutput("arst_nrr_done_addr", 32'(nrr_done_addr), 32'd0);
        checkOutput("arst_rfm_timeout", 32'(rfm_timeout), 32'd0);
        checkOutput("arst_raa_cnt", 32'(raa_cnt), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        checkOutput("arst_idle_ready", 32'(req_ready), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 18'h0F0F);
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (nrr_done || rfm_timeout) saw = 1'b1;
            idle_cycle();
        end
        checkOutput("arst_no_stray", 32'(saw), 32'd0);

        // Random traffic against the reference model
        do_reset();
        nlev = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5, 0) == 0) nlev = ~nlev;
            applyStimulus(($urandom_range(9, 0) < 7) ? 1'b1 : 1'b0,
                          addr_t'($urandom),
                          ($urandom_range(39, 0) == 0) ? 1'b1 : 1'b0,
                          nlev,
                          addr_t'($urandom));
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
